// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: walks the four CNN layers issuing one weight beat per MAC tap
// and waits for the accumulator to retire each neuron before moving on.
module cnn_layer_sequencer #(
  parameter int WADDR_W = 11,
  parameter int BADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [WADDR_W-1:0] w_addr,
  output logic [BADDR_W-1:0] b_addr,
  output logic               req_first,
  output logic               req_last,
  output logic [1:0]         layer_id,
  output logic [4:0]         neuron_idx,
  input  logic               acc_done,
  output logic               busy,
  output logic               layer_done,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACC, DONE} state_t;
  state_t state_q, state_d;
  logic [WADDR_W-1:0] w_addr_q, w_addr_d;
  logic [BADDR_W-1:0] b_addr_q, b_addr_d;
  logic [1:0] layer_q, layer_d;
  logic [4:0] neuron_q, neuron_d;
  logic [6:0] tap_q, tap_d;
  logic layer_done_q, layer_done_d;
  logic [6:0] taps_m1;
  logic [4:0] outs_m1;
  logic last_tap, last_neuron;
  always_comb begin
    taps_m1 = layer_q == 2'd0 ? 7'd8 : layer_q == 2'd1 ? 7'd71 : layer_q == 2'd2 ? 7'd15 : 7'd7;
    outs_m1 = layer_q == 2'd0 ? 5'd7 : layer_q == 2'd1 ? 5'd15 : layer_q == 2'd2 ? 5'd7 : 5'd0;
    last_tap = tap_q == taps_m1;
    last_neuron = neuron_q == outs_m1;
    state_d = state_q;
    w_addr_d = w_addr_q;
    b_addr_d = b_addr_q;
    layer_d = layer_q;
    neuron_d = neuron_q;
    tap_d = tap_q;
    layer_done_d = 1'b0;
    // abort outranks every transition and suppresses any pulse
    if (abort || state_q == IDLE) begin
      state_d = (!abort && start) ? ISSUE : IDLE;
      w_addr_d = '0;
      b_addr_d = '0;
      layer_d = '0;
      neuron_d = '0;
      tap_d = '0;
    end else begin
      case (state_q)
        ISSUE: if (req_ready) begin
          w_addr_d = w_addr_q + 1'b1;
          state_d = last_tap ? WAIT_ACC : ISSUE;
          tap_d = last_tap ? tap_q : tap_q + 1'b1;
        end
        WAIT_ACC: if (acc_done) begin
          tap_d = '0;
          layer_done_d = last_neuron;
          state_d = (last_neuron && layer_q == 2'd3) ? DONE : ISSUE;
          b_addr_d = (last_neuron && layer_q == 2'd3) ? b_addr_q : b_addr_q + 1'b1;
          neuron_d = last_neuron ? 5'd0 : neuron_q + 1'b1;
          layer_d = (last_neuron && layer_q != 2'd3) ? layer_q + 1'b1 : layer_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_addr_q <= '0;
      b_addr_q <= '0;
      layer_q <= '0;
      neuron_q <= '0;
      tap_q <= '0;
      layer_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_addr_q <= w_addr_d;
      b_addr_q <= b_addr_d;
      layer_q <= layer_d;
      neuron_q <= neuron_d;
      tap_q <= tap_d;
      layer_done_q <= layer_done_d;
    end
  end
  assign req_valid = state_q == ISSUE;
  assign req_first = req_valid && tap_q == 7'd0;
  assign req_last = req_valid && last_tap;
  assign w_addr = w_addr_q;
  assign b_addr = b_addr_q;
  assign layer_id = layer_q;
  assign neuron_idx = neuron_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign layer_done = layer_done_q;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: scoreboard of expected beats plus a boundary-beat table,
// exercising full, stalled, aborted and reset-interrupted inferences.
module tb_cnn_layer_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, req_ready = 1'b0, acc_done = 1'b0;
  logic req_valid, req_first, req_last, busy, layer_done, done;
  logic [10:0] w_addr;
  logic [5:0] b_addr;
  logic [1:0] layer_id;
  logic [4:0] neuron_idx;
  cnn_layer_sequencer #(.WADDR_W(11), .BADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .w_addr(w_addr), .b_addr(b_addr),
    .req_first(req_first), .req_last(req_last), .layer_id(layer_id), .neuron_idx(neuron_idx),
    .acc_done(acc_done), .busy(busy), .layer_done(layer_done), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [10:0] w;
    logic [5:0] b;
    logic f;
    logic l;
    logic [1:0] ly;
    logic [4:0] n;
  } beat_t;
  typedef struct {
    int idx;
    beat_t exp;
  } vec_t;
  beat_t exp_q[$];
  beat_t obs[1360];
  vec_t tbl[9];
  int errors = 0, checks = 0;
  int nbeats, n_ld, n_done, done_cyc, idle_cyc;
  localparam int LIMIT = 10000;
  function automatic beat_t mk(input int w, input int b, input int f, input int l, input int ly, input int n);
    beat_t r;
    r.w = 11'(w);
    r.b = 6'(b);
    r.f = 1'(f);
    r.l = 1'(l);
    r.ly = 2'(ly);
    r.n = 5'(n);
    return r;
  endfunction
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic load_exp();
    int taps[4] = '{9, 72, 16, 8};
    int outs[4] = '{8, 16, 8, 1};
    int wa = 0, ba = 0;
    exp_q.delete();
    for (int l = 0; l < 4; l++)
      for (int n = 0; n < outs[l]; n++) begin
        for (int t = 0; t < taps[l]; t++) begin
          exp_q.push_back(mk(wa, ba, int'(t == 0), int'(t == taps[l] - 1), l, n));
          wa++;
        end
        ba++;
      end
  endtask
  function automatic longint all_outs();
    return longint'({req_valid, w_addr, b_addr, req_first, req_last, layer_id, neuron_idx, busy, layer_done, done});
  endfunction
  task automatic run(input bit rnd, input int abort_beat, input int rst_cyc);
    int cyc, wcnt = 0, dly = 0;
    bit prev_stall = 1'b0;
    beat_t cur, prev = '0, e;
    nbeats = 0; n_ld = 0; n_done = 0; done_cyc = -1; idle_cyc = -1;
    load_exp();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; req_ready = 1'b0; acc_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 1; cyc <= LIMIT; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      start = !rnd && (cyc == 10 || cyc == 500);
      req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      abort = abort_beat >= 0 && req_valid && nbeats == abort_beat;
      if (!rnd) acc_done = 1'b1;
      else if (busy && !req_valid && !done) begin
        if (wcnt >= dly) begin
          acc_done = 1'b1; wcnt = 0; dly = $urandom_range(0, 5);
        end else begin
          acc_done = 1'b0; wcnt++;
        end
      end else acc_done = 1'($urandom_range(0, 1));
      if (cyc == rst_cyc) begin
        #1 rst_n = 1'b0;
        #1 chk("rst_async_outs", all_outs(), 0);
        start = 1'b0; acc_done = 1'b0; req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        break;
      end
      @(negedge clk);
      cur = {w_addr, b_addr, req_first, req_last, layer_id, neuron_idx};
      if (prev_stall) chk("stall_hold", longint'({req_valid, cur}), longint'({1'b1, prev}));
      prev_stall = req_valid && !req_ready && !abort;
      prev = cur;
      if (layer_done) n_ld++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (abort) begin
        chk("abort_pos", longint'(cur), longint'(exp_q[0]));
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", longint'({busy, req_valid, w_addr, done, layer_done}), 0);
        break;
      end
      if (req_valid && req_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", longint'(cur), 0);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", nbeats), longint'(cur), longint'(e));
        end
        if (nbeats < 1360) obs[nbeats] = cur;
        nbeats++;
      end
      if (!busy && n_done > 0) begin idle_cyc = cyc; break; end
    end
    if (cyc > LIMIT) chk("timeout", 1, 0);
    abort = 1'b0; start = 1'b0; req_ready = 1'b0; acc_done = 1'b0;
  endtask
  task automatic full_checks(input string nm);
    chk({nm, "_beats"}, nbeats, 1360);
    chk({nm, "_layer_done"}, n_ld, 4);
    chk({nm, "_done_cnt"}, n_done, 1);
    chk({nm, "_left"}, exp_q.size(), 0);
  endtask
  initial begin
    tbl = '{
      '{0,    mk(0,    0,  1, 0, 0, 0)},
      '{8,    mk(8,    0,  0, 1, 0, 0)},
      '{71,   mk(71,   7,  0, 1, 0, 7)},
      '{72,   mk(72,   8,  1, 0, 1, 0)},
      '{1223, mk(1223, 23, 0, 1, 1, 15)},
      '{1224, mk(1224, 24, 1, 0, 2, 0)},
      '{1351, mk(1351, 31, 0, 1, 2, 7)},
      '{1352, mk(1352, 32, 1, 0, 3, 0)},
      '{1359, mk(1359, 32, 0, 1, 3, 0)}
    };
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    run(1'b0, -1, -1);
    full_checks("full");
    chk("done_cycle", done_cyc, 1394);
    chk("idle_cycle", idle_cyc, 1395);
    for (int i = 0; i < 9; i++)
      chk($sformatf("tbl_beat%0d", tbl[i].idx), longint'(obs[tbl[i].idx]), longint'(tbl[i].exp));
    run(1'b1, -1, -1);
    full_checks("rand");
    run(1'b0, 462, -1);
    chk("abort_beats", nbeats, 462);
    chk("abort_no_done", n_done, 0);
    run(1'b0, -1, -1);
    full_checks("after_abort");
    chk("after_abort_done_cycle", done_cyc, 1394);
    run(1'b0, -1, 700);
    chk("rst_no_done", n_done, 0);
    run(1'b0, -1, -1);
    full_checks("after_rst");
    chk("after_rst_done_cycle", done_cyc, 1394);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
